pb_debounce_encoder: RTL
========================

# pb_debounce_encoder

Input conditioning stage between the board pushbutton pins and the student `top` design. Synchronizes all 21 raw pushbutton lines into `hwclk`, debounces each one, and produces clean levels, single-cycle press strobes and a valid/ready stream of pressed-button codes buffered in a small FIFO. `top` consumes levels, strobes or codes, so it never sees bounce or metastable inputs.

## Interface
- `NUM_PB`, 21: number of pushbutton lines; code width is 5 bits, fixed.
- `TICK_DIV`, 12000: `hwclk` cycles per debounce tick; 1 ms at 12 MHz.
- `STABLE_TICKS`, 5: consecutive ticks a new input value must persist before it is accepted; legal range 2–15.
- `FIFO_DEPTH`, 4: key code FIFO entries; power of two.
- `hwclk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `pb_raw`  in  NUM_PB  raw asynchronous button inputs; 1 = pressed.
- `pb_level`  out  NUM_PB  debounced button levels.
- `pb_press`  out  NUM_PB  one-cycle strobe on each debounced 0→1 transition.
- `key_code`  out  5  FIFO head: index of the pressed button.
- `key_valid`  out  1  FIFO non-empty.
- `key_ready`  in  1  consumer accepts the head this cycle.
- `overflow`  out  1  sticky flag: a press was lost; cleared only by `reset`.

## Operation
- Synchronizer: two flops per bit, both reset to 0. `sync[i]` is the second-stage output.
- Tick prescaler: counter runs 0..TICK_DIV-1 and wraps to 0. `tick` is high in the cycle where count == TICK_DIV-1.
- Per-button debounce, with a counter of width ceil(log2(STABLE_TICKS)):
  - If `sync[i]` == `pb_level[i]`: counter <= 0 every cycle.
  - Else on `tick`: if counter == STABLE_TICKS-1, then `pb_level[i]` <= `sync[i]` and counter <= 0; otherwise counter increments.
  - Else (no tick): counter holds.
  - Any bounce back to the current level restarts the qualification.
- `pb_press[i]` is registered. It is 1 in exactly the cycle where `pb_level[i]` first reads 1. A release (1→0) produces no strobe and no key.
- Encoder:
  - In a cycle with any `pb_press` bit set, the lowest set index is pushed to the FIFO.
  - If more than one bit is set, the remaining presses are dropped and `overflow` is set.
- FIFO (show-ahead):
  - `key_valid` = !empty; `key_code` = head entry.
  - Pop when `key_valid && key_ready`.
  - Push while full with a simultaneous pop: accepted, and occupancy stays full.
  - Push while full without a pop: the new code is discarded and `overflow` is set.
  - Pointers are one bit wider than log2(FIFO_DEPTH) and wrap naturally.
  - Push while empty: `key_valid` rises in the next cycle. There is no fall-through within the push cycle.
- Reset, including mid-operation, takes effect on the clock edge with `reset` high. It clears the synchronizer, prescaler, all debounce counters, levels, strobes, the FIFO pointers and `overflow`.

## Timing
- Reset values: `pb_level`=0, `pb_press`=0, `key_code`=0, `key_valid`=0, `overflow`=0.
- Synchronizer latency: 2 cycles.
- Debounce acceptance latency from the first edge of `sync`: between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV cycles, depending on prescaler phase.
- `pb_press` coincides with the `pb_level` rise. The FIFO entry is visible (`key_valid`=1) one cycle later.
- Pop takes effect at the clock edge. The next head appears in the following cycle, or `key_valid` falls if the FIFO is empty.
- Throughput: one push and one pop per cycle. `key_ready` has no combinational path to any output.

## Test plan
All scenarios use TICK_DIV=4, STABLE_TICKS=3.
- Hold `pb_raw`=all ones during 2 reset cycles → all outputs 0 throughout reset. After release, `pb_level` becomes all ones within 2+12 cycles, with `overflow`=1 (simultaneous presses) and `key_code`=0.
- From reset, raise `pb_raw[5]` and hold, with `key_ready`=0 → `pb_level[5]` rises 11–14 cycles after the input edge. `pb_press[5]` is high for exactly 1 cycle. The next cycle shows `key_valid`=1, `key_code`=5, and both hold. Pulse `key_ready` for one cycle → `key_valid`=0.
- Pulse `pb_raw[2]` high for 7 cycles, then low → `pb_level[2]` stays 0, no strobe, `key_valid` stays 0.
- Raise `pb_raw[3]` and `pb_raw[7]` in the same cycle → a single entry `key_code`=3, and `overflow`=1.
- With `key_ready`=0, press and release buttons 1, 4, 9, 12, 20 in sequence → FIFO holds 1, 4, 9, 12; button 20 is dropped and `overflow`=1. Then hold `key_ready`=1 → codes 1, 4, 9, 12 are popped on consecutive cycles and `key_valid`=0 after the 4th pop.
- With 2 entries queued and `pb_level[6]`=1, assert `reset` for 1 cycle → the next cycle shows `key_valid`=0, `pb_level`=0 and `overflow`=0.

Source files
------------

// File: rtl/pb_debounce_encoder.sv
// Pushbutton conditioning: 2-flop synchronizer, tick-based per-button debounce,
// registered press strobes and a small show-ahead FIFO of pressed-button codes.
module pb_debounce_encoder #(
  parameter int unsigned NUM_PB       = 21,
  parameter int unsigned TICK_DIV     = 12000,
  parameter int unsigned STABLE_TICKS = 5,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              hwclk,
  input  logic              reset,
  input  logic [NUM_PB-1:0] pb_raw,
  output logic [NUM_PB-1:0] pb_level,
  output logic [NUM_PB-1:0] pb_press,
  output logic [4:0]        key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              overflow
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE_TICKS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TickMax = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CntMax  = CW'(STABLE_TICKS - 1);

  logic [NUM_PB-1:0] sync1_q, sync2_q;
  logic [TW-1:0]     div_q;
  logic              tick;
  logic [CW-1:0]     cnt_q [NUM_PB];
  logic [CW-1:0]     cnt_d [NUM_PB];
  logic [NUM_PB-1:0] level_q, level_d;
  logic [NUM_PB-1:0] press_q;
  logic [4:0]        push_code;
  logic              any_press, multi_press;
  logic [4:0]        mem_q [FIFO_DEPTH];
  logic [AW:0]       wptr_q, rptr_q;
  logic              empty, full, pop, push_ok, drop;
  logic              ovf_q;

  // Two-stage synchronizer for the asynchronous button pins
  always_ff @(posedge hwclk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pb_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce tick prescaler, counts 0..TICK_DIV-1
  always_ff @(posedge hwclk) begin
    if (reset || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + TW'(1);
    end
  end

  assign tick = (div_q == TickMax);

  // Per-button qualification: a differing level must survive STABLE_TICKS ticks
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_PB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounce state, levels and rising-edge strobes
  always_ff @(posedge hwclk) begin
    if (reset) begin
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < NUM_PB; i++) cnt_q[i] <= '0;
    end else begin
      level_q <= level_d;
      press_q <= level_d & ~level_q;
      for (int i = 0; i < NUM_PB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Priority encoder: lowest strobed index wins, extra strobes are lost
  always_comb begin
    push_code = '0;
    for (int i = NUM_PB - 1; i >= 0; i--) begin
      if (press_q[i]) push_code = 5'(i);
    end
  end

  assign any_press   = |press_q;
  // Clearing the lowest set bit leaves something only if two or more were set
  assign multi_press = |(press_q & (press_q - NUM_PB'(1)));

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = !empty && key_ready;
  assign push_ok = any_press && (!full || pop);
  assign drop    = any_press && full && !pop;

  // Key FIFO storage, pointers and sticky overflow
  always_ff @(posedge hwclk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q[AW-1:0]] <= push_code;
        wptr_q                <= wptr_q + (AW + 1)'(1);
      end
      if (pop) rptr_q <= rptr_q + (AW + 1)'(1);
      if (drop || multi_press) ovf_q <= 1'b1;
    end
  end

  assign pb_level  = level_q;
  assign pb_press  = press_q;
  assign key_valid = !empty;
  assign key_code  = mem_q[rptr_q[AW-1:0]];
  assign overflow  = ovf_q;

endmodule
